// File: rtl/pipeline_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: fetch defaults,
// kernel-mode bit position and the IF/ID payload layout.
package pipeline_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned PcWidth    = 32;
  localparam int unsigned KernelBit  = 31;

  localparam logic [PcWidth-1:0]    ResetPcDefault   = 32'h0000_0000;
  localparam logic [PcWidth-1:0]    IrqVectorDefault = 32'h8000_0004;
  localparam logic [InstrWidth-1:0] NopWordDefault   = 32'h0000_0000;

  typedef struct packed {
    logic [InstrWidth-1:0] instruction;
    logic [PcWidth-1:0]    pc_plus4;
    logic                  valid;
  } if_id_t;

  // The kernel bit survives the increment; only the low bits wrap.
  function automatic logic [PcWidth-1:0] pc_increment(input logic [PcWidth-1:0] pc);
    return {pc[KernelBit], pc[KernelBit-1:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Pipeline register between fetch and decode with flush, hold and load controls.
// Flush beats hold beats load; with no control asserted the contents are kept.
module if_id_register
  import pipeline_pkg::*;
#(
  parameter logic [InstrWidth-1:0] NOP_WORD = NopWordDefault
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic                  i_hold,
  input  logic [InstrWidth-1:0] i_instruction,
  input  logic [PcWidth-1:0]    i_pc_plus4,
  output logic [InstrWidth-1:0] o_instruction,
  output logic [PcWidth-1:0]    o_pc_plus4,
  output logic                  o_valid
);

  if_id_t stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (i_flush) begin
      stage_d.instruction = NOP_WORD;
      stage_d.valid       = 1'b0;
    end else if (i_load && !i_hold) begin
      stage_d.instruction = i_instruction;
      stage_d.pc_plus4    = i_pc_plus4;
      stage_d.valid       = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_q.instruction <= NOP_WORD;
      stage_q.pc_plus4    <= '0;
      stage_q.valid       <= 1'b0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_instruction = stage_q.instruction;
  assign o_pc_plus4    = stage_q.pc_plus4;
  assign o_valid       = stage_q.valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, arbitrates branch/stall/jump/interrupt/sequential
// next-PC sources and fills the IF/ID register.
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [PcWidth-1:0]    RESET_PC   = ResetPcDefault,
  parameter logic [PcWidth-1:0]    IRQ_VECTOR = IrqVectorDefault,
  parameter logic [InstrWidth-1:0] NOP_WORD   = NopWordDefault
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [PcWidth-1:0]    o_pc,
  input  logic [InstrWidth-1:0] i_instruction,
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [PcWidth-1:0]    i_jump_target,
  input  logic                  i_branch_taken,
  input  logic [PcWidth-1:0]    i_branch_target,
  input  logic                  i_irq,
  output logic [InstrWidth-1:0] o_id_instruction,
  output logic [PcWidth-1:0]    o_id_pc_plus4,
  output logic                  o_id_valid,
  output logic [PcWidth-1:0]    o_epc,
  output logic                  o_irq_taken
);

  logic [PcWidth-1:0] pc_q, pc_d;
  logic [PcWidth-1:0] epc_q, epc_d;
  logic               irq_taken_q, irq_taken_d;
  logic [PcWidth-1:0] pc_plus4;
  logic               ifid_load, ifid_flush, ifid_hold;

  assign pc_plus4 = pc_increment(pc_q);

  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    irq_taken_d = 1'b0;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_hold   = 1'b0;
    // EX branch is the oldest redirect, so it wins even over a load-use stall.
    if (i_branch_taken) begin
      pc_d       = i_branch_target;
      ifid_flush = 1'b1;
    end else if (i_stall) begin
      ifid_hold = 1'b1;
    end else if (i_jump) begin
      pc_d       = i_jump_target;
      ifid_flush = 1'b1;
    end else if (i_irq && !pc_q[KernelBit]) begin
      pc_d        = IRQ_VECTOR;
      epc_d       = pc_q;
      irq_taken_d = 1'b1;
      ifid_flush  = 1'b1;
    end else begin
      pc_d      = pc_plus4;
      ifid_load = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      irq_taken_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      irq_taken_q <= irq_taken_d;
    end
  end

  if_id_register #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (ifid_load),
    .i_flush      (ifid_flush),
    .i_hold       (ifid_hold),
    .i_instruction(i_instruction),
    .i_pc_plus4   (pc_plus4),
    .o_instruction(o_id_instruction),
    .o_pc_plus4   (o_id_pc_plus4),
    .o_valid      (o_id_valid)
  );

  assign o_pc        = pc_q;
  assign o_epc       = epc_q;
  assign o_irq_taken = irq_taken_q;

endmodule
